// File: rtl/micro_sequencer.sv
// micro_sequencer
// Microprogram sequencer and control store for the multicycle MIPS datapath.
// The registered micro-PC (upc) indexes a 10-entry microcode ROM. The ROM
// drives the datapath controls combinationally and also carries an
// address-control field that picks the next upc: fetch, sequential,
// dispatch table 1 or dispatch table 2. The memory states 0, 3 and 5 hold
// while mem_ready is low.
//
// Ports:
//   clk            rising-edge clock
//   rst            asynchronous active-high reset (upc=0, illegal_op=0)
//   dispatch1      target from dispatch table 1 (used in state 1)
//   dispatch2      target from dispatch table 2 (used in state 2)
//   mem_ready      memory access completes this cycle
//   upc            current micro-PC (registered)
//   illegal_op     one-cycle registered pulse after an out-of-range dispatch
//   pc_write .. alu_src_b   datapath controls decoded from upc
module micro_sequencer #(
    parameter int UPC_W      = 4,
    parameter int NUM_STATES = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [UPC_W-1:0] dispatch1,
    input  logic [UPC_W-1:0] dispatch2,
    input  logic             mem_ready,
    output logic [UPC_W-1:0] upc,
    output logic             illegal_op,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             mem_to_reg,
    output logic             alu_src_a,
    output logic             reg_write,
    output logic             reg_dst,
    output logic [1:0]       pc_source,
    output logic [1:0]       alu_op,
    output logic [1:0]       alu_src_b
);

    localparam logic [1:0] AC_FETCH = 2'd0;
    localparam logic [1:0] AC_DISP1 = 2'd1;
    localparam logic [1:0] AC_DISP2 = 2'd2;
    localparam logic [1:0] AC_SEQ   = 2'd3;

    localparam logic [UPC_W-1:0] LAST_STATE = UPC_W'(NUM_STATES - 1);

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic       reg_write;
        logic       reg_dst;
        logic [1:0] pc_source;
        logic [1:0] alu_op;
        logic [1:0] alu_src_b;
        logic [1:0] ac;
        logic       mem_wait;   // state waits for mem_ready before advancing
    } uinstr_t;

    // Microcode store. Out-of-range addresses decode to all-zero controls
    // with AC=fetch so a corrupted upc recovers on the next edge.
    function automatic uinstr_t rom(input logic [UPC_W-1:0] addr);
        uinstr_t u;
        u    = '0;
        u.ac = AC_FETCH;
        case (int'(addr))
            0: begin
                u.mem_read  = 1'b1;
                u.ir_write  = 1'b1;
                u.pc_write  = 1'b1;
                u.alu_src_b = 2'b01;
                u.ac        = AC_SEQ;
                u.mem_wait  = 1'b1;
            end
            1: begin
                u.alu_src_b = 2'b11;
                u.ac        = AC_DISP1;
            end
            2: begin
                u.alu_src_a = 1'b1;
                u.alu_src_b = 2'b10;
                u.ac        = AC_DISP2;
            end
            3: begin
                u.mem_read = 1'b1;
                u.iord     = 1'b1;
                u.ac       = AC_SEQ;
                u.mem_wait = 1'b1;
            end
            4: begin
                u.reg_write  = 1'b1;
                u.mem_to_reg = 1'b1;
            end
            5: begin
                u.mem_write = 1'b1;
                u.iord      = 1'b1;
                u.mem_wait  = 1'b1;
            end
            6: begin
                u.alu_src_a = 1'b1;
                u.alu_op    = 2'b10;
                u.ac        = AC_SEQ;
            end
            7: begin
                u.reg_write = 1'b1;
                u.reg_dst   = 1'b1;
            end
            8: begin
                u.alu_src_a     = 1'b1;
                u.alu_op        = 2'b01;
                u.pc_write_cond = 1'b1;
                u.pc_source     = 2'b01;
            end
            9: begin
                u.pc_write  = 1'b1;
                u.pc_source = 2'b10;
            end
            default: ;
        endcase
        return u;
    endfunction

    logic [UPC_W-1:0] upc_q, upc_d;
    logic             illegal_q, illegal_d;
    uinstr_t          ui;
    logic             stall;

    assign ui    = rom(upc_q);
    assign stall = ui.mem_wait & ~mem_ready;

    always_comb begin
        upc_d     = upc_q;
        illegal_d = 1'b0;
        if (!stall) begin
            case (ui.ac)
                AC_FETCH: upc_d = '0;
                AC_SEQ:   upc_d = upc_q + UPC_W'(1);
                AC_DISP1: begin
                    // A zero target would re-fetch without executing, so it
                    // is flagged the same as an out-of-range one.
                    if (dispatch1 == '0 || dispatch1 > LAST_STATE) begin
                        upc_d     = '0;
                        illegal_d = 1'b1;
                    end else begin
                        upc_d = dispatch1;
                    end
                end
                default: begin
                    // Zero is the legitimate "no memory op" target here.
                    if (dispatch2 > LAST_STATE) begin
                        upc_d     = '0;
                        illegal_d = 1'b1;
                    end else begin
                        upc_d = dispatch2;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            upc_q     <= '0;
            illegal_q <= 1'b0;
        end else begin
            upc_q     <= upc_d;
            illegal_q <= illegal_d;
        end
    end

    assign upc        = upc_q;
    assign illegal_op = illegal_q;

    // PC and IR commit only on the cycle the fetch completes.
    assign pc_write      = ui.pc_write & (~ui.mem_wait | mem_ready);
    assign ir_write      = ui.ir_write & mem_ready;
    assign pc_write_cond = ui.pc_write_cond;
    assign iord          = ui.iord;
    assign mem_read      = ui.mem_read;
    assign mem_write     = ui.mem_write;
    assign mem_to_reg    = ui.mem_to_reg;
    assign alu_src_a     = ui.alu_src_a;
    assign reg_write     = ui.reg_write;
    assign reg_dst       = ui.reg_dst;
    assign pc_source     = ui.pc_source;
    assign alu_op        = ui.alu_op;
    assign alu_src_b     = ui.alu_src_b;

endmodule

// File: tb/tb_micro_sequencer.sv
// Testbench for micro_sequencer: directed instruction paths, stalls, illegal
// dispatches and an asynchronous mid-instruction reset, followed by a
// randomized run checked cycle by cycle against a behavioural model.
module tb_micro_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] dispatch1, dispatch2;
    logic       mem_ready;
    logic [3:0] upc;
    logic       illegal_op;
    logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
    logic       mem_to_reg, alu_src_a, reg_write, reg_dst;
    logic [1:0] pc_source, alu_op, alu_src_b;
    logic [15:0] dut_ctrl;

    micro_sequencer #(.UPC_W(4), .NUM_STATES(10)) dut (
        .clk(clk), .rst(rst), .dispatch1(dispatch1), .dispatch2(dispatch2),
        .mem_ready(mem_ready), .upc(upc), .illegal_op(illegal_op),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .iord(iord),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .reg_write(reg_write),
        .reg_dst(reg_dst), .pc_source(pc_source), .alu_op(alu_op),
        .alu_src_b(alu_src_b)
    );

    always #5 clk = ~clk;

    assign dut_ctrl = {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
                       mem_to_reg, alu_src_a, reg_write, reg_dst,
                       pc_source, alu_op, alu_src_b};

    int tests = 0;
    int fails = 0;
    int m_upc;
    bit m_ill;
    int pw_count;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Expected datapath controls for a microinstruction, listed as the
    // signals each step of the multicycle MIPS flow asserts.
    function automatic logic [15:0] exp_ctrl(input int s, input bit rdy);
        logic pw, pwc, io, mr, mw, irw, m2r, asa, rw, rd;
        logic [1:0] ps, aop, asb;
        {pw, pwc, io, mr, mw, irw, m2r, asa, rw, rd} = '0;
        ps = 2'b00; aop = 2'b00; asb = 2'b00;
        case (s)
            0: begin mr = 1; irw = rdy; pw = rdy; asb = 2'b01; end
            1: asb = 2'b11;
            2: begin asa = 1; asb = 2'b10; end
            3: begin mr = 1; io = 1; end
            4: begin rw = 1; m2r = 1; end
            5: begin mw = 1; io = 1; end
            6: begin asa = 1; aop = 2'b10; end
            7: begin rw = 1; rd = 1; end
            8: begin asa = 1; aop = 2'b01; pwc = 1; ps = 2'b01; end
            9: begin pw = 1; ps = 2'b10; end
            default: ;
        endcase
        return {pw, pwc, io, mr, mw, irw, m2r, asa, rw, rd, ps, aop, asb};
    endfunction

    // Next micro-PC from the instruction-flow rules: memory steps wait for
    // ready, decode dispatches to a valid step 1..9, register-fetch may
    // dispatch to 0 (back to fetch); anything else is illegal.
    function automatic int model_next(input int s, input int d1, input int d2,
                                      input bit rdy, output bit ill);
        ill = 0;
        if ((s == 0 || s == 3 || s == 5) && !rdy) return s;
        case (s)
            0: return 1;
            1: begin
                if (d1 >= 1 && d1 <= 9) return d1;
                ill = 1;
                return 0;
            end
            2: begin
                if (d2 <= 9) return d2;
                ill = 1;
                return 0;
            end
            3: return 4;
            6: return 7;
            default: return 0;
        endcase
    endfunction

    // One clock step: drive inputs, check decoded controls, clock, check state.
    task automatic cycle(input int d1, input int d2, input bit rdy);
        bit ill;
        int nxt;
        dispatch1 = 4'(d1);
        dispatch2 = 4'(d2);
        mem_ready = rdy;
        #1;
        check("ctrl", dut_ctrl, exp_ctrl(m_upc, rdy));
        if (pc_write) pw_count++;
        nxt = model_next(m_upc, d1, d2, rdy, ill);
        @(posedge clk);
        m_upc = nxt;
        m_ill = ill;
        #1;
        check("upc", upc, m_upc);
        check("illegal_op", illegal_op, m_ill);
    endtask

    initial begin
        rst = 1'b1;
        dispatch1 = 4'd0;
        dispatch2 = 4'd0;
        mem_ready = 1'b1;
        m_upc = 0;
        m_ill = 0;
        pw_count = 0;

        // Reset state
        #2;
        check("rst_upc", upc, 0);
        check("rst_illegal", illegal_op, 0);
        check("rst_ctrl", dut_ctrl, exp_ctrl(0, 1));
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        // lw: 0,1,2,3,4,0
        cycle(2, 3, 1); check("lw_s1", upc, 1);
        cycle(2, 3, 1); check("lw_s2", upc, 2);
        cycle(2, 3, 1); check("lw_s3", upc, 3);
        cycle(2, 3, 1); check("lw_s4", upc, 4);
        check("lw_reg_write", reg_write, 1);
        check("lw_mem_to_reg", mem_to_reg, 1);
        cycle(2, 3, 1); check("lw_back", upc, 0);

        // Fetch stall: two not-ready cycles, exactly one pc_write pulse
        pw_count = 0;
        cycle(8, 0, 0); check("fstall_hold1", upc, 0);
        check("fstall_irw", ir_write, 0);
        cycle(8, 0, 0); check("fstall_hold2", upc, 0);
        cycle(8, 0, 1); check("fstall_adv", upc, 1);
        check("fstall_pw_pulses", pw_count, 1);

        // beq: 1 -> 8 -> 0
        cycle(8, 0, 1); check("beq_s8", upc, 8);
        check("beq_pwc", pc_write_cond, 1);
        check("beq_ps", pc_source, 2'b01);
        cycle(8, 0, 1); check("beq_back", upc, 0);

        // j: 0,1,9,0
        cycle(9, 0, 1);
        cycle(9, 0, 1); check("j_s9", upc, 9);
        check("j_pw", pc_write, 1);
        check("j_ps", pc_source, 2'b10);
        cycle(9, 0, 1); check("j_back", upc, 0);

        // sw with three not-ready cycles in state 5: 7 cycles total
        cycle(2, 5, 1);
        cycle(2, 5, 1);
        cycle(2, 5, 1); check("sw_s5", upc, 5);
        for (int i = 0; i < 3; i++) begin
            cycle(2, 5, 0);
            check("sw_hold", upc, 5);
            check("sw_mem_write", mem_write, 1);
        end
        cycle(2, 5, 1); check("sw_back", upc, 0);

        // Out-of-range dispatch1: one-cycle illegal pulse
        cycle(12, 0, 1);
        cycle(12, 0, 1); check("ill_d1_upc", upc, 0);
        check("ill_d1_flag", illegal_op, 1);
        cycle(2, 0, 1); check("ill_pulse_end", illegal_op, 0);
        // dispatch2=0 returns to fetch without flagging
        cycle(2, 0, 1);
        cycle(2, 0, 1); check("d2_zero_upc", upc, 0);
        check("d2_zero_flag", illegal_op, 0);
        // dispatch1=0 is illegal
        cycle(0, 0, 1);
        cycle(0, 0, 1); check("d1_zero_flag", illegal_op, 1);

        // Asynchronous reset while in state 6
        cycle(6, 0, 1);
        cycle(6, 0, 1); check("rtype_s6", upc, 6);
        mem_ready = 1'b0;
        rst = 1'b1;
        #1;
        check("arst_upc", upc, 0);
        check("arst_illegal", illegal_op, 0);
        check("arst_mem_read", mem_read, 1);
        check("arst_ir_write", ir_write, 0);
        #1 rst = 1'b0;
        m_upc = 0;
        m_ill = 0;

        // R-type: 0,1,6,7,0
        cycle(6, 0, 1);
        cycle(6, 0, 1);
        cycle(6, 0, 1); check("rtype_s7", upc, 7);
        cycle(6, 0, 1); check("rtype_back", upc, 0);

        // Randomized run against the model
        repeat (400) begin
            int d1, d2;
            bit rdy;
            d1 = int'($urandom_range(0, 15));
            case ($urandom_range(0, 3))
                0: d2 = 3;
                1: d2 = 5;
                2: d2 = 0;
                default: d2 = int'($urandom_range(0, 15));
            endcase
            rdy = ($urandom_range(0, 3) != 0);
            cycle(d1, d2, rdy);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/micro_sequencer.md
Name: micro_sequencer

Overview:
- Microprogram sequencer and control store for the multicycle MIPS datapath.
- Holds the registered micro-PC (upc) and decodes it into datapath control signals through an internal 10-entry microcode ROM.
- Selects the next upc from the current microinstruction's address-control field: fetch, sequential, dispatch table 1 or dispatch table 2.
- Consumes the 4-bit dispatch ROM outputs; memory states stall on a ready handshake.

Parameters:
- UPC_W, 4, micro-PC width.
- NUM_STATES, 10, number of valid microinstructions (upc 0..9).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- dispatch1  input  4  target from dispatch table 1.
- dispatch2  input  4  target from dispatch table 2 (lw→3, sw→5, otherwise 0).
- mem_ready  input  1  memory access complete this cycle.
- upc  output  4  current micro-PC (registered).
- illegal_op  output  1  registered one-cycle pulse on an out-of-range dispatch.
- pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, mem_to_reg, alu_src_a, reg_write, reg_dst  output  1 each  datapath controls.
- pc_source, alu_op, alu_src_b  output  2 each  datapath controls.

Behaviour:
- Reset, asynchronous:
  - upc=0 and illegal_op=0 immediately.
  - Control outputs then show the state-0 decode, with pc_write/ir_write gated by mem_ready.
- Control outputs are combinational from upc (plus mem_ready gating). upc advances only on the rising clk edge.
- Address control (AC) per microinstruction: 0=fetch (next=0), 1=dispatch1, 2=dispatch2, 3=seq (upc+1).
- Microcode ROM (state: asserted signals; AC). Unlisted controls are 0.
  - 0: mem_read, ir_write, pc_write, alu_src_b=01, alu_op=00, pc_source=00; seq.
  - 1: alu_src_b=11, alu_op=00; dispatch1.
  - 2: alu_src_a=1, alu_src_b=10; dispatch2.
  - 3: mem_read, iord; seq.
  - 4: reg_write, mem_to_reg, reg_dst=0; fetch.
  - 5: mem_write, iord; fetch.
  - 6: alu_src_a=1, alu_src_b=00, alu_op=10; seq.
  - 7: reg_write, reg_dst=1, mem_to_reg=0; fetch.
  - 8: alu_src_a=1, alu_op=01, pc_write_cond, pc_source=01; fetch.
  - 9: pc_write, pc_source=10; fetch.
- Memory stall:
  - In states 0, 3 and 5, upc holds while mem_ready=0.
  - mem_read/mem_write/iord stay asserted during the stall.
  - pc_write and ir_write in state 0 are ANDed with mem_ready, so the PC and IR commit exactly once.
  - In all other states mem_ready is ignored.
- Dispatch range check:
  - A dispatch value of 0 or ≥NUM_STATES selects next upc=0.
  - Exception: dispatch2 value 0 from state 2 also returns to fetch.
  - Out-of-range (≥10) sets illegal_op=1 for exactly the following cycle.
  - dispatch1=0 from state 1 is treated as illegal (no valid instruction re-fetches without executing).
- Any upc ≥10 (unreachable) decodes all controls to 0 with AC=fetch.
- Path lengths, assuming mem_ready=1:
  - lw = 5 cycles (0,1,2,3,4).
  - sw = 4 cycles (0,1,2,5).
  - R-type = 4 cycles (0,1,6,7).
  - beq = 3 cycles (0,1,8).
  - j = 3 cycles (0,1,9).
- Reset asserted mid-instruction aborts immediately to upc=0. The first edge after deassertion behaves as a normal state-0 cycle.

Test Plan:
- rst pulse while upc=6 → upc=0 immediately, without a clock edge; illegal_op=0; mem_read=1; ir_write=mem_ready.
- lw: dispatch1=2, dispatch2=3, mem_ready=1 → upc sequence 0,1,2,3,4,0. reg_write=1 and mem_to_reg=1 only in state 4.
- sw with mem_ready low for 3 cycles in state 5 → upc stays at 5 for 4 cycles with mem_write=1 throughout, then returns to 0. Total 7 cycles.
- Fetch stall: mem_ready=0 for 2 cycles in state 0 → pc_write=ir_write=0 during the stall; exactly one pc_write pulse, on the mem_ready cycle.
- beq (dispatch1=8) → 0,1,8,0 with pc_write_cond=1 and pc_source=01 in state 8. j (dispatch1=9) → pc_write=1 and pc_source=10 in state 9.
- dispatch1=12 in state 1 → next upc=0 and illegal_op=1 for exactly one cycle. dispatch2=0 in state 2 → next upc=0 with illegal_op=0.
